bsr_siso: RTL and testbench

- 4-bit (parameterizable) bidirectional serial-in/serial-out shift register.
- One serial input enters at the end selected by `mode`; one serial output leaves at the opposite end.
- The full register contents are also exposed as a parallel observation bus `srtb`, for debug/verification.
- Used as a leaf storage/delay element in serial datapaths.

---
 rtl/bsr_siso.sv | 38 +++
 tb/tb_bsr_siso.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/bsr_siso.sv
// Bidirectional serial-in/serial-out shift register with parallel
// observation bus; mode selects the entry end for sin.
module bsr_siso #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             mode,
  output logic             sout,
  output logic [WIDTH-1:0] srtb
);

  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_d;

  always_comb begin
    sr_d = sr_q;
    unique case (1'b1)
      mode:  sr_d = {sr_q[WIDTH-2:0], sin};
      !mode: sr_d = {sin, sr_q[WIDTH-1:1]};
      default: sr_d = sr_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  // Exit end follows the live mode, so a mode flip moves sout at once.
  assign sout = mode ? sr_q[WIDTH-1] : sr_q[0];
  assign srtb = sr_q;

endmodule

// File: tb/tb_bsr_siso.sv
// Self-checking bench for bsr_siso: vector table, corner sequences
// and a randomized run against an arithmetic reference model.
module tb_bsr_siso;

  localparam int W = 4;
  localparam int MASK = (1 << W) - 1;

  logic         clk;
  logic         rst;
  logic         sin;
  logic         mode;
  logic         sout;
  logic [W-1:0] srtb;

  int n_checks;
  int n_fail;
  int m;

  bsr_siso #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .sin  (sin),
    .mode (mode),
    .sout (sout),
    .srtb (srtb)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    bit       r;
    bit       s;
    bit       md;
    bit [3:0] e_srtb;
    bit       e_sout;
  } vec_t;

  vec_t vt[12];

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp,
               $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_step(input bit s, input bit md);
    if (md) m = ((m << 1) | int'(s)) & MASK;
    else    m = (m >> 1) | (int'(s) << (W - 1));
  endtask

  function automatic int exp_sout(input int v, input bit md);
    return md ? ((v >> (W - 1)) & 1) : (v & 1);
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m = 0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst  = 1'b1;
    sin  = 1'b1;
    mode = 1'b1;
    #1;
    chk("reset_async_srtb", 32'(srtb), 0);
    chk("reset_async_sout", 32'(sout), 0);

    vt[0]  = '{1, 1, 1, 4'b0000, 0};
    vt[1]  = '{1, 0, 0, 4'b0000, 0};
    vt[2]  = '{0, 1, 1, 4'b0001, 0};
    vt[3]  = '{0, 0, 1, 4'b0010, 0};
    vt[4]  = '{0, 1, 1, 4'b0101, 0};
    vt[5]  = '{0, 1, 1, 4'b1011, 1};
    vt[6]  = '{1, 1, 0, 4'b0000, 0};
    vt[7]  = '{0, 1, 0, 4'b1000, 0};
    vt[8]  = '{0, 0, 0, 4'b0100, 0};
    vt[9]  = '{0, 0, 0, 4'b0010, 0};
    vt[10] = '{0, 1, 0, 4'b1001, 1};
    vt[11] = '{1, 0, 1, 4'b0000, 0};

    for (int i = 0; i < 12; i++) begin
      rst  = vt[i].r;
      sin  = vt[i].s;
      mode = vt[i].md;
      tick();
      chk($sformatf("vec%0d_srtb", i), 32'(srtb), 32'(vt[i].e_srtb));
      chk($sformatf("vec%0d_sout", i), 32'(sout), 32'(vt[i].e_sout));
    end

    // Full pass-through: one 1 travels WIDTH edges to sout.
    rst = 1'b0;
    mode = 1'b1;
    for (int e = 1; e <= W + 1; e++) begin
      sin = (e == 1);
      tick();
      chk($sformatf("pass_edge%0d_sout", e), 32'(sout),
          32'(e == W));
    end

    // Load 1010, then flip mode with no clock edge.
    do_reset();
    mode = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sin = (i % 2 == 0);
      tick();
    end
    chk("load1010_srtb", 32'(srtb), 32'hA);
    chk("mode1_sout", 32'(sout), 1);
    #2 mode = 1'b0;
    #1;
    chk("modeflip_sout", 32'(sout), 0);
    chk("modeflip_srtb", 32'(srtb), 32'hA);

    // Async clear mid-stream, held across edges, then resume.
    do_reset();
    mode = 1'b1;
    sin = 1'b1; tick();
    sin = 1'b0; tick();
    sin = 1'b1; tick();
    sin = 1'b1; tick();
    chk("load1011_srtb", 32'(srtb), 32'hB);
    #2 rst = 1'b1;
    #1;
    chk("midrst_srtb", 32'(srtb), 0);
    chk("midrst_sout", 32'(sout), 0);
    sin = 1'b1;
    tick();
    tick();
    chk("rsthold_srtb", 32'(srtb), 0);
    rst = 1'b0;
    sin = 1'b1;
    mode = 1'b1;
    tick();
    chk("resume_srtb", 32'(srtb), 1);

    // Randomized run against the arithmetic model.
    m = 1;
    for (int c = 0; c < 300; c++) begin
      if ($urandom_range(0, 24) == 0) begin
        #2 rst = 1'b1;
        #1;
        m = 0;
        chk("rnd_async_srtb", 32'(srtb), 32'(m));
        sin  = 1'($urandom);
        mode = 1'($urandom);
        tick();
        rst = 1'b0;
        chk("rnd_rsthold_srtb", 32'(srtb), 0);
      end else begin
        sin  = 1'($urandom);
        mode = 1'($urandom);
        tick();
        model_step(sin, mode);
        chk("rnd_srtb", 32'(srtb), 32'(m));
        chk("rnd_sout", 32'(sout), 32'(exp_sout(m, mode)));
        if ($urandom_range(0, 3) == 0) begin
          #2 mode = ~mode;
          #1;
          chk("rnd_modeflip_sout", 32'(sout),
              32'(exp_sout(m, mode)));
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
